// File: rtl/sisc_ifetch_pkg.sv
// Shared constants and FSM encoding for the sisc instruction-fetch stage.
package sisc_ifetch_pkg;

    localparam int DEF_PC_W    = 16;
    localparam int DEF_INSTR_W = 32;

    localparam logic [3:0]             OP_HALT = 4'hF;
    localparam logic [DEF_INSTR_W-1:0] OP_NOP  = '0;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_DONE = 2'd2
    } fetch_state_e;

endpackage

// File: rtl/sisc_ifetch_if.sv
// Instruction-memory read port: registered request/address out, data/valid back.
interface sisc_ifetch_if
    import sisc_ifetch_pkg::*;
#(
    parameter int PC_W    = DEF_PC_W,
    parameter int INSTR_W = DEF_INSTR_W
);
    logic               req;
    logic [PC_W-1:0]    addr;
    logic [INSTR_W-1:0] rdata;
    logic               valid;

    modport master (output req, addr, input rdata, valid);
    modport slave  (input req, addr, output rdata, valid);
endinterface

// File: rtl/sisc_ifetch_pc.sv
// Program counter with sequential / relative / absolute next-PC selection.
module sisc_ifetch_pc
    import sisc_ifetch_pkg::*;
#(
    parameter int PC_W = DEF_PC_W
) (
    input  logic            clk_i,
    input  logic            rst_i,
    input  logic            pc_write_i,
    input  logic            pc_sel_i,
    input  logic            br_sel_i,
    input  logic [15:0]     imm_i,
    output logic [PC_W-1:0] pc_o
);
    logic [PC_W-1:0] pc_q, pc_d;
    logic [PC_W-1:0] pc_inc;
    logic [PC_W-1:0] imm_ext;

    // Immediate is treated as unsigned; mod-2^PC_W wrap makes 0xFFFF behave as -1.
    assign imm_ext = PC_W'(imm_i);
    assign pc_inc  = pc_q + PC_W'(1);

    always_comb begin
        pc_d = pc_q;
        if (pc_write_i) begin
            if (!pc_sel_i)
                pc_d = pc_inc;
            else if (br_sel_i)
                pc_d = imm_ext;
            else
                pc_d = pc_inc + imm_ext;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i)
            pc_q <= '0;
        else
            pc_q <= pc_d;
    end

    assign pc_o = pc_q;
endmodule

// File: rtl/sisc_ifetch.sv
// Fetch stage: issues imem reads, captures IR, latches HALT, hosts the PC unit.
//   state   | meaning
//   ST_IDLE | waiting for FETCH (blocked while halted)
//   ST_REQ  | request outstanding, waiting for valid
//   ST_DONE | IR just loaded, FETCH_DONE high this cycle
module sisc_ifetch
    import sisc_ifetch_pkg::*;
#(
    parameter int PC_W    = DEF_PC_W,
    parameter int INSTR_W = DEF_INSTR_W
) (
    input  logic               clk_i,
    input  logic               rst_i,
    input  logic               fetch_i,
    input  logic               pc_write_i,
    input  logic               pc_sel_i,
    input  logic               br_sel_i,
    sisc_ifetch_if.master      imem,
    output logic [INSTR_W-1:0] ir_o,
    output logic [PC_W-1:0]    pc_o,
    output logic               fetch_done_o,
    output logic               halted_o
);
    fetch_state_e       state_q, state_d;
    logic               req_q, req_d;
    logic [PC_W-1:0]    addr_q, addr_d;
    logic [INSTR_W-1:0] ir_q, ir_d;
    logic               done_q, done_d;
    logic               halted_q, halted_d;
    logic [PC_W-1:0]    pc;

    // Branch immediate comes from the registered IR, so a same-edge load never feeds itself.
    sisc_ifetch_pc #(.PC_W(PC_W)) u_pc (
        .clk_i      (clk_i),
        .rst_i      (rst_i),
        .pc_write_i (pc_write_i),
        .pc_sel_i   (pc_sel_i),
        .br_sel_i   (br_sel_i),
        .imm_i      (ir_q[15:0]),
        .pc_o       (pc)
    );

    always_comb begin
        state_d  = state_q;
        req_d    = req_q;
        addr_d   = addr_q;
        ir_d     = ir_q;
        done_d   = 1'b0;
        halted_d = halted_q;
        case (state_q)
            ST_IDLE: begin
                if (fetch_i && !halted_q) begin
                    state_d = ST_REQ;
                    req_d   = 1'b1;
                    addr_d  = pc;
                end
            end
            ST_REQ: begin
                if (imem.valid) begin
                    state_d = ST_DONE;
                    req_d   = 1'b0;
                    ir_d    = imem.rdata;
                    done_d  = 1'b1;
                    if (imem.rdata[INSTR_W-1 -: 4] == OP_HALT)
                        halted_d = 1'b1;
                end
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q  <= ST_IDLE;
            req_q    <= 1'b0;
            addr_q   <= '0;
            ir_q     <= INSTR_W'(OP_NOP);
            done_q   <= 1'b0;
            halted_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            req_q    <= req_d;
            addr_q   <= addr_d;
            ir_q     <= ir_d;
            done_q   <= done_d;
            halted_q <= halted_d;
        end
    end

    assign imem.req     = req_q;
    assign imem.addr    = addr_q;
    assign ir_o         = ir_q;
    assign pc_o         = pc;
    assign fetch_done_o = done_q;
    assign halted_o     = halted_q;
endmodule

// File: tb/tb_sisc_ifetch.sv
// Scenario bench for sisc_ifetch with a wait-state memory model and an IR scoreboard.
module tb_sisc_ifetch;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        fetch = 1'b0;
    logic        pc_write = 1'b0;
    logic        pc_sel = 1'b0;
    logic        br_sel = 1'b0;
    logic [31:0] ir;
    logic [15:0] pc;
    logic        fetch_done;
    logic        halted;

    int errors = 0;
    int checks = 0;

    logic [31:0] mem [0:65535];
    logic [31:0] exp_q [$];
    int          wait_states = 0;
    int          wcnt = 0;
    bit          mem_en = 1'b1;
    logic        r_valid = 1'b0;
    logic [31:0] r_rdata = '0;
    logic        m_valid = 1'b0;
    logic [31:0] m_rdata = '0;

    sisc_ifetch_if #(.PC_W(16), .INSTR_W(32)) imem ();

    assign imem.valid = mem_en ? r_valid : m_valid;
    assign imem.rdata = mem_en ? r_rdata : m_rdata;

    sisc_ifetch #(.PC_W(16), .INSTR_W(32)) dut (
        .clk_i        (clk),
        .rst_i        (rst),
        .fetch_i      (fetch),
        .pc_write_i   (pc_write),
        .pc_sel_i     (pc_sel),
        .br_sel_i     (br_sel),
        .imem         (imem),
        .ir_o         (ir),
        .pc_o         (pc),
        .fetch_done_o (fetch_done),
        .halted_o     (halted)
    );

    always #5 clk = ~clk;

    // Memory responds wait_states cycles after it first sees a request.
    always @(negedge clk) begin
        #1;
        if (imem.req && !rst) begin
            if (wcnt == wait_states) begin
                r_valid = 1'b1;
                r_rdata = mem[imem.addr];
                wcnt    = 0;
            end else begin
                r_valid = 1'b0;
                wcnt    = wcnt + 1;
            end
        end else begin
            r_valid = 1'b0;
            wcnt    = 0;
        end
    end

    task automatic apply_reset();
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
    endtask

    // Pulses FETCH for one edge; returns at the negedge after that edge.
    task automatic start_fetch(input logic [15:0] addr);
        @(negedge clk);
        fetch = 1'b1;
        exp_q.push_back(mem[addr]);
        @(negedge clk);
        fetch = 1'b0;
    endtask

    task automatic pc_cmd(input logic sel, input logic br);
        @(negedge clk);
        pc_write = 1'b1;
        pc_sel   = sel;
        br_sel   = br;
        @(negedge clk);
        pc_write = 1'b0;
    endtask

    task automatic wait_done(input int budget, output int cyc, output int reqc, output bit ok);
        cyc = 0; reqc = 0; ok = 1'b0;
        while (cyc < budget) begin
            if (imem.req) reqc++;
            @(negedge clk);
            cyc++;
            if (fetch_done) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic test_reset();
        apply_reset();
        checks++; if (pc !== 16'h0)  begin errors++; $display("FAIL reset_pc got=%h exp=0000", pc); end
        checks++; if (ir !== 32'h0)  begin errors++; $display("FAIL reset_ir got=%h exp=00000000", ir); end
        checks++; if (imem.req !== 1'b0) begin errors++; $display("FAIL reset_req got=%b exp=0", imem.req); end
        checks++; if (imem.addr !== 16'h0) begin errors++; $display("FAIL reset_addr got=%h exp=0000", imem.addr); end
        checks++; if (fetch_done !== 1'b0) begin errors++; $display("FAIL reset_done got=%b exp=0", fetch_done); end
        checks++; if (halted !== 1'b0) begin errors++; $display("FAIL reset_halted got=%b exp=0", halted); end
    endtask

    task automatic test_zero_wait();
        int cyc, reqc; bit ok; logic [31:0] e;
        wait_states = 0;
        mem[0] = 32'h88010001;
        start_fetch(16'h0000);
        checks++; if (imem.req !== 1'b1) begin errors++; $display("FAIL zw_req got=%b exp=1", imem.req); end
        checks++; if (imem.addr !== 16'h0000) begin errors++; $display("FAIL zw_addr got=%h exp=0000", imem.addr); end
        wait_done(20, cyc, reqc, ok);
        checks++; if (!ok) begin errors++; $display("FAIL zw_timeout got=none exp=fetch_done"); end
        checks++; if (cyc !== 1) begin errors++; $display("FAIL zw_latency got=%0d exp=1", cyc); end
        e = exp_q.pop_front();
        checks++; if (ir !== e) begin errors++; $display("FAIL zw_ir got=%h exp=%h", ir, e); end
        @(negedge clk);
        checks++; if (fetch_done !== 1'b0) begin errors++; $display("FAIL zw_done_pulse got=%b exp=0", fetch_done); end
    endtask

    task automatic test_wait_states();
        int cyc, reqc, extra; bit ok; logic [31:0] e;
        pc_cmd(1'b0, 1'b0);
        checks++; if (pc !== 16'h0001) begin errors++; $display("FAIL ws_pc_inc got=%h exp=0001", pc); end
        wait_states = 3;
        mem[1] = 32'h00000010;
        start_fetch(16'h0001);
        fetch = 1'b1;
        @(negedge clk);
        fetch = 1'b0;
        wait_done(20, cyc, reqc, ok);
        checks++; if (!ok) begin errors++; $display("FAIL ws_timeout got=none exp=fetch_done"); end
        checks++; if (reqc + 1 !== 4) begin errors++; $display("FAIL ws_req_cycles got=%0d exp=4", reqc + 1); end
        e = exp_q.pop_front();
        checks++; if (ir !== e) begin errors++; $display("FAIL ws_ir got=%h exp=%h", ir, e); end
        extra = 0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (imem.req || fetch_done) extra++;
        end
        checks++; if (extra !== 0) begin errors++; $display("FAIL ws_queued_fetch got=%0d exp=0", extra); end
        wait_states = 0;
    endtask

    task automatic test_branch();
        int cyc, reqc; bit ok; logic [31:0] e;
        pc_cmd(1'b1, 1'b1);
        checks++; if (pc !== 16'h0010) begin errors++; $display("FAIL br_abs_setup got=%h exp=0010", pc); end
        mem[16'h0010] = 32'h0000FFFC;
        start_fetch(16'h0010);
        wait_done(20, cyc, reqc, ok);
        e = exp_q.pop_front();
        checks++; if (!ok || ir !== e) begin errors++; $display("FAIL br_ir_fffc got=%h exp=%h", ir, e); end
        pc_cmd(1'b1, 1'b0);
        checks++; if (pc !== 16'h000D) begin errors++; $display("FAIL br_rel_neg got=%h exp=000D", pc); end
        mem[16'h000D] = 32'h00000200;
        start_fetch(16'h000D);
        wait_done(20, cyc, reqc, ok);
        e = exp_q.pop_front();
        checks++; if (!ok || ir !== e) begin errors++; $display("FAIL br_ir_0200 got=%h exp=%h", ir, e); end
        pc_cmd(1'b1, 1'b1);
        checks++; if (pc !== 16'h0200) begin errors++; $display("FAIL br_abs got=%h exp=0200", pc); end
        // Relative branch on the very edge IR reloads: must use the old IR (0x0200).
        mem[16'h0200] = 32'h00000300;
        start_fetch(16'h0200);
        pc_write = 1'b1; pc_sel = 1'b1; br_sel = 1'b0;
        @(negedge clk);
        pc_write = 1'b0;
        e = exp_q.pop_front();
        checks++; if (fetch_done !== 1'b1 || ir !== e) begin errors++; $display("FAIL br_same_edge_ir got=%h done=%b exp=%h", ir, fetch_done, e); end
        checks++; if (pc !== 16'h0401) begin errors++; $display("FAIL br_same_edge_pc got=%h exp=0401", pc); end
    endtask

    task automatic test_wrap();
        int cyc, reqc; bit ok; logic [31:0] e;
        mem[16'h0401] = 32'h0000FFFF;
        start_fetch(16'h0401);
        checks++; if (imem.addr !== 16'h0401) begin errors++; $display("FAIL wrap_addr got=%h exp=0401", imem.addr); end
        wait_done(20, cyc, reqc, ok);
        e = exp_q.pop_front();
        checks++; if (!ok || ir !== e) begin errors++; $display("FAIL wrap_ir got=%h exp=%h", ir, e); end
        pc_cmd(1'b1, 1'b1);
        checks++; if (pc !== 16'hFFFF) begin errors++; $display("FAIL wrap_setup got=%h exp=FFFF", pc); end
        pc_cmd(1'b0, 1'b0);
        checks++; if (pc !== 16'h0000) begin errors++; $display("FAIL wrap_pc got=%h exp=0000", pc); end
    endtask

    task automatic test_halt();
        int cyc, reqc, reqs; bit ok; logic [31:0] e;
        mem[0] = 32'hF0000000;
        start_fetch(16'h0000);
        wait_done(20, cyc, reqc, ok);
        e = exp_q.pop_front();
        checks++; if (!ok || ir !== e) begin errors++; $display("FAIL halt_ir got=%h exp=%h", ir, e); end
        checks++; if (halted !== 1'b1) begin errors++; $display("FAIL halt_set got=%b exp=1", halted); end
        @(negedge clk);
        fetch = 1'b1;
        @(negedge clk);
        fetch = 1'b0;
        reqs = 0;
        for (int i = 0; i < 5; i++) begin
            if (imem.req) reqs++;
            @(negedge clk);
        end
        checks++; if (reqs !== 0) begin errors++; $display("FAIL halt_blocks_fetch got=%0d exp=0", reqs); end
        pc_cmd(1'b0, 1'b0);
        checks++; if (pc !== 16'h0001) begin errors++; $display("FAIL halt_pc_write got=%h exp=0001", pc); end
        apply_reset();
        checks++; if (halted !== 1'b0) begin errors++; $display("FAIL halt_clear got=%b exp=0", halted); end
        checks++; if (pc !== 16'h0000) begin errors++; $display("FAIL halt_rst_pc got=%h exp=0000", pc); end
    endtask

    task automatic test_reset_mid_fetch();
        mem_en = 1'b0;
        @(negedge clk);
        fetch = 1'b1;
        @(negedge clk);
        fetch = 1'b0;
        checks++; if (imem.req !== 1'b1) begin errors++; $display("FAIL rmf_req got=%b exp=1", imem.req); end
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        m_valid = 1'b1;
        m_rdata = 32'h12345678;
        @(negedge clk);
        m_valid = 1'b0;
        checks++; if (ir !== 32'h0) begin errors++; $display("FAIL rmf_ir got=%h exp=00000000", ir); end
        checks++; if (fetch_done !== 1'b0) begin errors++; $display("FAIL rmf_done got=%b exp=0", fetch_done); end
        checks++; if (imem.req !== 1'b0) begin errors++; $display("FAIL rmf_req_drop got=%b exp=0", imem.req); end
        @(negedge clk);
        checks++; if (fetch_done !== 1'b0) begin errors++; $display("FAIL rmf_done_late got=%b exp=0", fetch_done); end
        mem_en = 1'b1;
    endtask

    initial begin
        test_reset();
        test_zero_wait();
        test_wait_states();
        test_branch();
        test_wrap();
        test_halt();
        test_reset_mid_fetch();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
